hmcs_timer_irq: RTL and testbench

- Parametrised timer/counter and interrupt controller for the HMCS4x-class MCU cores.
- Generalises the single 4-bit timer/counter and fixed int0/int1/timer interrupt logic to CH channels, CW-bit counters, auto-reload and NEXT external inputs.
- Sources are arbitrated by fixed priority into a vector index.
- Sits beside the core; the core accesses it through a small register port and takes irq/irq_idx into its PC-load logic.

---
 rtl/hmcs_tc_pkg.sv | 28 ++
 rtl/hmcs_tc_channel.sv | 59 +++++
 rtl/hmcs_timer_irq.sv | 154 +++++++++++++++
 tb/tb_hmcs_timer_irq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmcs_tc_pkg.sv
// Register map, CTRL bit positions and helpers shared by the HMCS timer/interrupt block.
package hmcs_tc_pkg;

    localparam logic [4:0] ADDR_IMASK = 5'h00;
    localparam logic [4:0] ADDR_IPEND = 5'h01;
    localparam logic [4:0] ADDR_IECTL = 5'h02;
    localparam logic [4:0] CH_BASE    = 5'h04;

    localparam logic [1:0] OFF_COUNT  = 2'd0;
    localparam logic [1:0] OFF_RELOAD = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int CTRL_CF  = 0;
    localparam int CTRL_ARE = 1;
    localparam int CTRL_RUN = 2;
    localparam int CTRL_W   = 3;

    // Lowest set bit wins, so source 0 has the highest priority.
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hmcs_tc_channel.sv
// One timer/counter channel: counter, reload value, CTRL, event-input sync and overflow pulse.
module hmcs_tc_channel
    import hmcs_tc_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              po,
    input  logic              cnt_in,
    input  logic              we_count,
    input  logic              we_reload,
    input  logic              we_ctrl,
    input  logic [CW-1:0]     wdata,
    input  logic [CTRL_W-1:0] wctrl,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     reload,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ovf
);

    logic sync1;
    logic sync2;
    logic prev;
    logic edge_det;
    logic inc;
    logic at_max;

    assign edge_det = ce && sync2 && !prev;
    assign inc      = ce && ctrl[CTRL_RUN] && (ctrl[CTRL_CF] ? edge_det : po);
    assign at_max   = (count == {CW{1'b1}});
    // A coincident COUNT write suppresses the overflow it would have replaced.
    assign ovf      = inc && at_max && !we_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            count  <= '0;
            reload <= '0;
            ctrl   <= '0;
        end else begin
            sync1 <= cnt_in;
            sync2 <= sync1;
            if (ce) prev <= sync2;
            if (we_reload) reload <= wdata;
            if (we_ctrl) ctrl <= wctrl;
            if (we_count) begin
                count <= wdata;
            end else if (inc) begin
                if (at_max) count <= ctrl[CTRL_ARE] ? reload : '0;
                else        count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hmcs_timer_irq.sv
// Timer/counter and interrupt controller for HMCS4x-class cores: CH channels, NEXT external
// inputs, fixed-priority arbitration into irq/irq_idx, accessed through a small register port.
module hmcs_timer_irq
    import hmcs_tc_pkg::*;
#(
    parameter int CH   = 2,
    parameter int CW   = 4,
    parameter int PW   = 6,
    parameter int NEXT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [NEXT-1:0] ext_int,
    input  logic [CH-1:0]   cnt_in,
    input  logic            reg_we,
    input  logic            reg_re,
    input  logic [4:0]      reg_addr,
    input  logic [7:0]      reg_wdata,
    output logic [7:0]      reg_rdata,
    output logic            irq,
    output logic [2:0]      irq_idx,
    input  logic            irq_ack
);

    localparam int NSRC = NEXT + CH;

    logic [PW-1:0]     prescaler;
    logic              po;
    logic [NEXT-1:0]   ext_s1;
    logic [NEXT-1:0]   ext_s2;
    logic [NEXT-1:0]   ext_prev;
    logic [NEXT-1:0]   ext_rise;
    logic [NSRC-1:0]   imask;
    logic [NSRC-1:0]   ipend;
    logic [NSRC-1:0]   act;
    logic [NSRC-1:0]   ipend_set;
    logic [NSRC-1:0]   ipend_clr;
    logic              ie;
    logic              ack;
    logic [CH-1:0]     ovf;
    logic [CH-1:0]     we_count;
    logic [CH-1:0]     we_reload;
    logic [CH-1:0]     we_ctrl;
    logic [CH-1:0]     cf;
    logic [CW-1:0]     count_v  [CH];
    logic [CW-1:0]     reload_v [CH];
    logic [CTRL_W-1:0] ctrl_v   [CH];
    logic [4:0]        ch_off;
    logic              ch_space;
    logic              clear_pre;
    logic [7:0]        rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign ch_off    = reg_addr - CH_BASE;
    assign ch_space  = (reg_addr >= CH_BASE);
    assign po        = ce && (prescaler == {PW{1'b1}});
    assign ext_rise  = ce ? (ext_s2 & ~ext_prev) : '0;
    assign ipend_set = {ovf, ext_rise};
    assign ack       = irq_ack && irq;
    assign act       = ipend & imask;
    // Reloading a timer-mode counter restarts the prescaler so the first period is full length.
    assign clear_pre = |(we_count & ~cf);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign we_count[c]  = reg_we && ch_space && (ch_off[4:2] == 3'(c)) && (ch_off[1:0] == OFF_COUNT);
        assign we_reload[c] = reg_we && ch_space && (ch_off[4:2] == 3'(c)) && (ch_off[1:0] == OFF_RELOAD);
        assign we_ctrl[c]   = reg_we && ch_space && (ch_off[4:2] == 3'(c)) && (ch_off[1:0] == OFF_CTRL);
        assign cf[c]        = ctrl_v[c][CTRL_CF];

        hmcs_tc_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .po        (po),
            .cnt_in    (cnt_in[c]),
            .we_count  (we_count[c]),
            .we_reload (we_reload[c]),
            .we_ctrl   (we_ctrl[c]),
            .wdata     (reg_wdata[CW-1:0]),
            .wctrl     (reg_wdata[CTRL_W-1:0]),
            .count     (count_v[c]),
            .reload    (reload_v[c]),
            .ctrl      (ctrl_v[c]),
            .ovf       (ovf[c])
        );
    end

    always_comb begin
        ipend_clr = '0;
        if (reg_we && reg_addr == ADDR_IPEND) ipend_clr = reg_wdata[NSRC-1:0];
        for (int i = 0; i < NSRC; i++) begin
            if (ack && irq_idx == 3'(i)) ipend_clr[i] = 1'b1;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (reg_addr == ADDR_IMASK) begin
            rd_mux = 8'(imask);
        end else if (reg_addr == ADDR_IPEND) begin
            rd_mux = 8'(ipend);
        end else if (reg_addr == ADDR_IECTL) begin
            rd_mux = {7'b0, ie};
        end else if (ch_space) begin
            for (int c = 0; c < CH; c++) begin
                if (ch_off[4:2] == 3'(c)) begin
                    case (ch_off[1:0])
                        OFF_COUNT:  rd_mux = 8'(count_v[c]);
                        OFF_RELOAD: rd_mux = 8'(reload_v[c]);
                        OFF_CTRL:   rd_mux = 8'(ctrl_v[c]);
                        default:    rd_mux = 8'h00;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            ext_s1    <= '0;
            ext_s2    <= '0;
            ext_prev  <= '0;
            imask     <= '0;
            ipend     <= '0;
            ie        <= 1'b0;
            irq       <= 1'b0;
            irq_idx   <= 3'd0;
            reg_rdata <= 8'h00;
        end else begin
            ext_s1 <= ext_int;
            ext_s2 <= ext_s1;
            if (ce) ext_prev <= ext_s2;

            if (clear_pre) prescaler <= '0;
            else if (ce)   prescaler <= prescaler + 1'b1;

            if (reg_we && reg_addr == ADDR_IMASK) imask <= reg_wdata[NSRC-1:0];
            // New events override a coincident write-1-to-clear.
            ipend <= (ipend & ~ipend_clr) | ipend_set;

            if (ack) ie <= 1'b0;
            else if (reg_we && reg_addr == ADDR_IECTL) ie <= reg_wdata[0];

            irq     <= !ack && ie && |act;
            irq_idx <= first_set(8'(act));

            if (reg_re) reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_hmcs_timer_irq.sv
// Directed bench for hmcs_timer_irq: register vector table plus timer, counter, priority/ack corner sequences.
module tb_hmcs_timer_irq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic [1:0] ext_int = 2'b00;
    logic [1:0] cnt_in = 2'b00;
    logic       reg_we = 1'b0;
    logic       reg_re = 1'b0;
    logic [4:0] reg_addr = 5'h00;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;
    logic       irq;
    logic [2:0] irq_idx;
    logic       irq_ack = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    hmcs_timer_irq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .ext_int   (ext_int),
        .cnt_in    (cnt_in),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq       (irq),
        .irq_idx   (irq_idx),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        reg_we = 1'b1;
        reg_addr = a;
        reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        reg_re = 1'b1;
        reg_addr = a;
        tick();
        reg_re = 1'b0;
        check(name, reg_rdata, exp);
    endtask

    task automatic ce_ticks(input int n);
        ce = 1'b1;
        for (int i = 0; i < n; i++) tick();
        ce = 1'b0;
    endtask

    task automatic reset_and_check(input string tag);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check({tag, "_irq"}, {7'b0, irq}, 8'h00);
        check({tag, "_idx"}, {5'b0, irq_idx}, 8'h00);
        check({tag, "_rdata"}, reg_rdata, 8'h00);
        rd_check({tag, "_imask"}, 5'h00, 8'h00);
        rd_check({tag, "_ipend"}, 5'h01, 8'h00);
        rd_check({tag, "_ie"}, 5'h02, 8'h00);
        rd_check({tag, "_count0"}, 5'h04, 8'h00);
        rd_check({tag, "_count1"}, 5'h08, 8'h00);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 8'h0A, 8'h0A};
        vecs[1]  = '{1'b1, 5'h00, 8'hFF, 8'h0F};
        vecs[2]  = '{1'b1, 5'h02, 8'hFF, 8'h01};
        vecs[3]  = '{1'b1, 5'h02, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 5'h05, 8'hFF, 8'h0F};
        vecs[5]  = '{1'b1, 5'h06, 8'hFB, 8'h03};
        vecs[6]  = '{1'b1, 5'h06, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 5'h08, 8'h09, 8'h09};
        vecs[8]  = '{1'b1, 5'h09, 8'h36, 8'h06};
        vecs[9]  = '{1'b1, 5'h07, 8'hFF, 8'h00};
        vecs[10] = '{1'b1, 5'h0C, 8'hFF, 8'h00};
        vecs[11] = '{1'b1, 5'h03, 8'hFF, 8'h00};
        vecs[12] = '{1'b1, 5'h01, 8'hFF, 8'h00};
        vecs[13] = '{1'b0, 5'h05, 8'h00, 8'h0F};

        reset_and_check("rst0");

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].wdata);
            rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        reg_addr = 5'h02;
        tick();
        check("rdata_hold", reg_rdata, 8'h0F);

        reset_and_check("rst1");

        // Timer overflow after 128 machine cycles, ce every 4 clocks.
        do_write(5'h04, 8'h0E);
        do_write(5'h06, 8'h04);
        do_write(5'h00, 8'h04);
        do_write(5'h02, 8'h01);
        for (int i = 0; i < 127; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
            tick();
            tick();
            tick();
        end
        rd_check("tmr_count_pre", 5'h04, 8'h0F);
        rd_check("tmr_ipend_pre", 5'h01, 8'h00);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        check("tmr_irq_lat", {7'b0, irq}, 8'h00);
        tick();
        check("tmr_irq", {7'b0, irq}, 8'h01);
        check("tmr_idx", {5'b0, irq_idx}, 8'h02);
        rd_check("tmr_count", 5'h04, 8'h00);
        rd_check("tmr_ipend", 5'h01, 8'h04);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("tmr_ack_irq", {7'b0, irq}, 8'h00);
        rd_check("tmr_ack_ipend", 5'h01, 8'h00);

        reset_and_check("rst2");

        // Counter mode with auto-reload.
        do_write(5'h09, 8'h0A);
        do_write(5'h08, 8'h0F);
        do_write(5'h0A, 8'h07);
        cnt_in = 2'b10;
        ce_ticks(5);
        rd_check("cnt_reload", 5'h08, 8'h0A);
        rd_check("cnt_ipend", 5'h01, 8'h08);
        cnt_in = 2'b00;
        ce_ticks(3);
        cnt_in = 2'b10;
        ce_ticks(3);
        rd_check("cnt_inc", 5'h08, 8'h0B);
        rd_check("cnt_ipend2", 5'h01, 8'h08);

        reset_and_check("rst3");

        // Priority and acknowledge.
        do_write(5'h00, 8'h03);
        do_write(5'h02, 8'h01);
        ext_int = 2'b11;
        tick();
        tick();
        ce_ticks(1);
        check("pri_lat", {7'b0, irq}, 8'h00);
        tick();
        check("pri_irq", {7'b0, irq}, 8'h01);
        check("pri_idx", {5'b0, irq_idx}, 8'h00);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_irq", {7'b0, irq}, 8'h00);
        rd_check("ack_ipend", 5'h01, 8'h02);
        rd_check("ack_ie", 5'h02, 8'h00);
        check("ack_irq_stay", {7'b0, irq}, 8'h00);
        do_write(5'h02, 8'h01);
        tick();
        check("reen_irq", {7'b0, irq}, 8'h01);
        check("reen_idx", {5'b0, irq_idx}, 8'h01);
        irq_ack = 1'b1;
        reg_we = 1'b1;
        reg_addr = 5'h02;
        reg_wdata = 8'h01;
        tick();
        irq_ack = 1'b0;
        reg_we = 1'b0;
        rd_check("ackwr_ie", 5'h02, 8'h00);
        rd_check("ackwr_ipend", 5'h01, 8'h00);
        check("ackwr_irq", {7'b0, irq}, 8'h00);
        do_write(5'h02, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        rd_check("ack_idle_ie", 5'h02, 8'h01);

        ext_int = 2'b00;
        reset_and_check("rst4");

        // COUNT write coinciding with an overflow increment.
        do_write(5'h04, 8'h0F);
        do_write(5'h06, 8'h04);
        ce_ticks(63);
        ce = 1'b1;
        reg_we = 1'b1;
        reg_addr = 5'h04;
        reg_wdata = 8'h05;
        tick();
        reg_we = 1'b0;
        ce = 1'b0;
        rd_check("cw_count", 5'h04, 8'h05);
        rd_check("cw_ipend", 5'h01, 8'h00);
        ce_ticks(63);
        rd_check("cw_pre_restart", 5'h04, 8'h05);
        ce_ticks(1);
        rd_check("cw_next_inc", 5'h04, 8'h06);

        reset_and_check("rst5");

        // IPEND write-1-to-clear coinciding with a new ext_int[0] edge.
        ext_int = 2'b01;
        tick();
        tick();
        tick();
        ce = 1'b1;
        reg_we = 1'b1;
        reg_addr = 5'h01;
        reg_wdata = 8'h01;
        tick();
        reg_we = 1'b0;
        ce = 1'b0;
        rd_check("w1c_race", 5'h01, 8'h01);
        do_write(5'h01, 8'h01);
        rd_check("w1c_clear", 5'h01, 8'h00);
        ext_int = 2'b00;
        ce_ticks(3);
        ext_int = 2'b01;
        ce_ticks(3);
        do_write(5'h00, 8'h01);
        do_write(5'h02, 8'h01);
        tick();
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        ext_int = 2'b00;
        reset_and_check("rst6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
